stage_id: RTL and testbench
===========================

Name: stage_ID

Overview:
- Decode stage sitting directly downstream of stage_IF.
- Consumes the synchronously-read instruction word and its aligned PC.
- Reads and writes the register file, detects load-use and branch hazards, and resolves BEQ in ID.
- Drives pc_write/pc_in back to stage_IF and presents a registered ID/EX bundle to the execute stage.

Parameters:
data_width, 32, register and operand width
imem_addr_width, 8, PC / instruction-memory byte-address width
reg_addr_width, 5, register-file index width (2**reg_addr_width entries)

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
inst  input  32  instruction word from stage_IF
inst_pc  input  imem_addr_width  byte address of inst (aligned with inst)
wb_we  input  1  writeback write enable
wb_addr  input  reg_addr_width  writeback destination
wb_data  input  data_width  writeback data
mem_rd  input  reg_addr_width  destination register of the instruction in MEM
mem_mem_read  input  1  instruction in MEM is LW
pc_write  output  1  to stage_IF: load pc_in
pc_in  output  imem_addr_width  to stage_IF: next PC
ex_valid  output  1  ID/EX bundle holds a real instruction
ex_rs_val, ex_rt_val  output  data_width  operand values
ex_imm  output  data_width  sign-extended imm[15:0]
ex_rd  output  reg_addr_width  destination (rd for R-type, rt for LW/ADDI)
ex_alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR
ex_alu_src  output  1  1 = use ex_imm as second operand
ex_mem_read, ex_mem_write, ex_reg_write  output  1  control bits

Behaviour:
- Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
  - opcode 0x00 = R-type; funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
  - 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ.
  - Any other opcode or funct issues as a bubble. BEQ and SW assert no reg_write.
- Register file:
  - Entry 0 reads 0 and ignores writes.
  - Writes happen on the clk edge.
  - Same-cycle write-before-read bypass: if wb_we and wb_addr==rs/rt, which is nonzero, the read returns wb_data.
- ID/EX register: updated every edge; decode-to-output latency is 1 cycle. A bubble clears ex_valid and all control bits; data fields are don't-care.
- State machine (current instruction = held copy in REPLAY, else inst/inst_pc):
  - RUN: decode the incoming inst.
  - REPLAY: decode the held copy; the incoming inst is discarded.
  - SQUASH: the incoming inst is wrong-path; issue a bubble.
- Hazards, evaluated only in RUN and REPLAY:
  - Load-use: ex_valid & ex_mem_read & ex_rd!=0 & ex_rd matches a source the instruction reads. Sources: rs for all; rt for R-type, SW and BEQ.
  - Branch: BEQ and (ex_valid & ex_reg_write & ex_rd matches rs/rt, nonzero) or (mem_mem_read & mem_rd matches rs/rt, nonzero).
  - On either hazard: issue a bubble, latch the current inst/inst_pc into the hold register, drive pc_write=1 and pc_in=inst_pc+4, next state REPLAY.
  - REPLAY re-evaluates hazards and may re-enter REPLAY. It keeps the held copy and redirects pc_in to held_pc+4 again.
- Branch resolution: BEQ with no hazard.
  - Equal operands: pc_write=1, pc_in = inst_pc + 4 + (sext(imm)<<2), truncated to imem_addr_width with wrap-around. Next state SQUASH.
  - Not taken: no pc_write; the bubble is issued, since BEQ produces no EX work.
- SQUASH always returns to RUN and never asserts pc_write.
- pc_write is combinational from current state and decode. pc_in = 0 when pc_write=0.
- Reset (async, low): state RUN, hold register 0, all ID/EX outputs 0, all register-file entries 0. Asserting reset mid-stall or mid-squash abandons the replay or squash.

Test Plan:
- Reset low mid-REPLAY -> next cycle ex_valid=0, pc_write=0, state RUN, r1 reads 0 after release.
- wb_we=1, wb_addr=3, wb_data=0x55 with inst ADD r4,r3,r0 in same cycle -> after edge ex_rs_val=0x55, ex_rd=4, ex_reg_write=1, ex_alu_op=0.
- LW r2,0(r0) then ADD r5,r2,r2 -> one bubble (ex_valid=0), pc_write=1 with pc_in=ADD_pc+4, ADD issues the next cycle; the incoming word that cycle is ignored.
- r1=r2=7, BEQ r1,r2,+3 at pc 0x10 -> pc_write=1, pc_in=0x20; the next inst is squashed (ex_valid=0).
- BEQ at pc 0xFC, imm=+1, imem_addr_width=8 -> pc_in wraps to 0x04.
- Write r0=0x99 then ADD r1,r0,r0 -> ex_rs_val=0; opcode 0x3F -> bubble, no pc_write.

Source files
------------

// File: rtl/stage_id.sv
// Decode stage: register file with writeback bypass, load-use/branch hazard
// detection, BEQ resolution in ID, and a registered ID/EX bundle.
module stage_id #(
   parameter int data_width      = 32,
   parameter int imem_addr_width = 8,
   parameter int reg_addr_width  = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                inst,
   input  logic [imem_addr_width-1:0] inst_pc,
   input  logic                       wb_we,
   input  logic [reg_addr_width-1:0]  wb_addr,
   input  logic [data_width-1:0]      wb_data,
   input  logic [reg_addr_width-1:0]  mem_rd,
   input  logic                       mem_mem_read,
   output logic                       pc_write,
   output logic [imem_addr_width-1:0] pc_in,
   output logic                       ex_valid,
   output logic [data_width-1:0]      ex_rs_val,
   output logic [data_width-1:0]      ex_rt_val,
   output logic [data_width-1:0]      ex_imm,
   output logic [reg_addr_width-1:0]  ex_rd,
   output logic [2:0]                 ex_alu_op,
   output logic                       ex_alu_src,
   output logic                       ex_mem_read,
   output logic                       ex_mem_write,
   output logic                       ex_reg_write
);

   typedef enum logic [1:0] {RUN, REPLAY, SQUASH} state_t;

   state_t                     state, nxt;
   logic [31:0]                hold_inst, cur_inst;
   logic [imem_addr_width-1:0] hold_pc, cur_pc, pc_plus4, br_tgt;
   logic [data_width-1:0]      rf [2**reg_addr_width];
   logic [data_width-1:0]      rs_val, rt_val, imm_ext, br_off;
   logic [reg_addr_width-1:0]  rs, rt, rd, dst;
   logic [5:0]                 op, funct;
   logic [2:0]                 alu_op;
   logic is_r, r_ok, is_addi, is_lw, is_sw, is_beq, legal, reads_rt;
   logic load_use, br_haz, hazard, issue, latch;

   assign cur_inst = (state == REPLAY) ? hold_inst : inst;
   assign cur_pc   = (state == REPLAY) ? hold_pc   : inst_pc;
   assign op       = cur_inst[31:26];
   assign funct    = cur_inst[5:0];
   assign rs       = reg_addr_width'(cur_inst[25:21]);
   assign rt       = reg_addr_width'(cur_inst[20:16]);
   assign rd       = reg_addr_width'(cur_inst[15:11]);
   assign imm_ext  = {{(data_width-16){cur_inst[15]}}, cur_inst[15:0]};
   assign br_off   = imm_ext << 2;
   assign pc_plus4 = cur_pc + imem_addr_width'(4);
   assign br_tgt   = pc_plus4 + br_off[imem_addr_width-1:0];

   assign is_r     = (op == 6'h00);
   assign is_addi  = (op == 6'h08);
   assign is_lw    = (op == 6'h23);
   assign is_sw    = (op == 6'h2B);
   assign is_beq   = (op == 6'h04);
   assign r_ok     = is_r && (funct == 6'h20 || funct == 6'h22 ||
                              funct == 6'h24 || funct == 6'h25);
   assign legal    = r_ok || is_addi || is_lw || is_sw || is_beq;
   assign reads_rt = r_ok || is_sw || is_beq;
   assign dst      = is_r ? rd : rt;

   always_comb begin
      alu_op = 3'd0;
      if (is_r) begin
         case (funct)
            6'h22:   alu_op = 3'd1;
            6'h24:   alu_op = 3'd2;
            6'h25:   alu_op = 3'd3;
            default: alu_op = 3'd0;
         endcase
      end
   end

   // Writeback in the same cycle wins over the stored value.
   always_comb begin
      rs_val = (rs == '0) ? '0 : rf[rs];
      rt_val = (rt == '0) ? '0 : rf[rt];
      if (wb_we && wb_addr == rs && rs != '0) rs_val = wb_data;
      if (wb_we && wb_addr == rt && rt != '0) rt_val = wb_data;
   end

   assign load_use = legal && ex_valid && ex_mem_read && ex_rd != '0 &&
                     (ex_rd == rs || (reads_rt && ex_rd == rt));
   assign br_haz   = is_beq &&
                     ((ex_valid && ex_reg_write && ex_rd != '0 && (ex_rd == rs || ex_rd == rt)) ||
                      (mem_mem_read && mem_rd != '0 && (mem_rd == rs || mem_rd == rt)));
   assign hazard   = load_use || br_haz;

   always_comb begin
      nxt      = RUN;
      issue    = 1'b0;
      latch    = 1'b0;
      pc_write = 1'b0;
      pc_in    = '0;
      case (state)
         SQUASH: nxt = RUN;
         default: begin
            if (hazard) begin
               latch    = 1'b1;
               pc_write = 1'b1;
               pc_in    = pc_plus4;
               nxt      = REPLAY;
            end else begin
               // Fetch has moved past held_pc+4 by now; point it back there.
               if (state == REPLAY) begin
                  pc_write = 1'b1;
                  pc_in    = pc_plus4;
               end
               if (is_beq) begin
                  if (rs_val == rt_val) begin
                     pc_write = 1'b1;
                     pc_in    = br_tgt;
                     nxt      = SQUASH;
                  end
               end else begin
                  issue = legal;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         hold_inst <= '0;
         hold_pc   <= '0;
         for (int i = 0; i < 2**reg_addr_width; i++) rf[i] <= '0;
      end else begin
         state <= nxt;
         if (latch) begin
            hold_inst <= cur_inst;
            hold_pc   <= cur_pc;
         end
         if (wb_we && wb_addr != '0) rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid     <= 1'b0;
         ex_rs_val    <= '0;
         ex_rt_val    <= '0;
         ex_imm       <= '0;
         ex_rd        <= '0;
         ex_alu_op    <= '0;
         ex_alu_src   <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_reg_write <= 1'b0;
      end else begin
         ex_valid     <= issue;
         ex_rs_val    <= rs_val;
         ex_rt_val    <= rt_val;
         ex_imm       <= imm_ext;
         ex_rd        <= dst;
         ex_alu_op    <= issue ? alu_op : 3'd0;
         ex_alu_src   <= issue && (is_addi || is_lw || is_sw);
         ex_mem_read  <= issue && is_lw;
         ex_mem_write <= issue && is_sw;
         ex_reg_write <= issue && (r_ok || is_addi || is_lw);
      end
   end

endmodule

// File: tb/tb_stage_id.sv
// Directed-vector bench for stage_id: bypass, hazards, BEQ redirect/squash, reset.
module tb_stage_id;

   logic        clk, reset;
   logic [31:0] inst;
   logic [7:0]  inst_pc;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  mem_rd;
   logic        mem_mem_read;
   logic        pc_write;
   logic [7:0]  pc_in;
   logic        ex_valid;
   logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_alu_op;
   logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] BUB = {6'h3F, 26'h0};

   stage_id dut (
      .clk(clk), .reset(reset), .inst(inst), .inst_pc(inst_pc),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
      .pc_write(pc_write), .pc_in(pc_in),
      .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
      .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; inst = BUB; inst_pc = '0; wb_we = 1'b0; wb_addr = '0;
      wb_data = '0; mem_rd = '0; mem_mem_read = 1'b0;
      repeat (2) step();
      chk("rst_valid", ex_valid, 0);
      chk("rst_pcw", pc_write, 0);
      chk("rst_pcin", pc_in, 0);
      chk("rst_regw", ex_reg_write, 0);
      reset = 1'b1;

      // Same-cycle writeback bypass
      inst = rtype(3, 0, 4, 6'h20); wb_we = 1; wb_addr = 3; wb_data = 32'h55;
      step(); wb_we = 0;
      chk("byp_valid", ex_valid, 1);
      chk("byp_rs", ex_rs_val, 32'h55);
      chk("byp_rd", ex_rd, 4);
      chk("byp_regw", ex_reg_write, 1);
      chk("byp_op", ex_alu_op, 0);

      inst = rtype(3, 3, 6, 6'h22); step();
      chk("sub_op", ex_alu_op, 1);
      chk("sub_rt", ex_rt_val, 32'h55);
      inst = rtype(0, 0, 6, 6'h25); step();
      chk("or_op", ex_alu_op, 3);
      inst = itype(6'h08, 0, 6, 16'hFFFE); step();
      chk("addi_imm", ex_imm, 32'hFFFF_FFFE);
      chk("addi_src", ex_alu_src, 1);
      chk("addi_rd", ex_rd, 6);
      inst = itype(6'h2B, 0, 3, 16'h4); step();
      chk("sw_memw", ex_mem_write, 1);
      chk("sw_regw", ex_reg_write, 0);

      // Load-use stall then replay
      inst = itype(6'h23, 0, 2, 0); inst_pc = 8'h20; step();
      chk("lw_memr", ex_mem_read, 1);
      chk("lw_rd", ex_rd, 2);
      inst = rtype(2, 2, 5, 6'h20); inst_pc = 8'h24; #1;
      chk("lu_pcw", pc_write, 1);
      chk("lu_pcin", pc_in, 8'h28);
      step();
      chk("lu_bubble", ex_valid, 0);
      inst = rtype(3, 3, 7, 6'h24); inst_pc = 8'h28;
      wb_we = 1; wb_addr = 2; wb_data = 32'h11;
      step(); wb_we = 0;
      chk("rp_valid", ex_valid, 1);
      chk("rp_rd", ex_rd, 5);
      chk("rp_op", ex_alu_op, 0);
      chk("rp_rs", ex_rs_val, 32'h11);

      // BEQ taken, then squash
      inst = BUB; wb_we = 1; wb_addr = 1; wb_data = 32'h7; step();
      wb_addr = 2; step(); wb_we = 0;
      inst = itype(6'h04, 1, 2, 16'd3); inst_pc = 8'h10; #1;
      chk("beq_pcw", pc_write, 1);
      chk("beq_pcin", pc_in, 8'h20);
      step();
      chk("beq_bubble", ex_valid, 0);
      inst = rtype(1, 1, 6, 6'h20); inst_pc = 8'h14; #1;
      chk("sq_pcw", pc_write, 0);
      step();
      chk("sq_valid", ex_valid, 0);

      // BEQ not taken: no redirect, next instruction issues
      inst = itype(6'h04, 1, 3, 16'd3); inst_pc = 8'h30; #1;
      chk("nt_pcw", pc_write, 0);
      step();
      chk("nt_bubble", ex_valid, 0);
      inst = rtype(1, 0, 6, 6'h20); inst_pc = 8'h34; step();
      chk("nt_next_valid", ex_valid, 1);
      chk("nt_next_rs", ex_rs_val, 32'h7);

      // Branch hazard on EX result, then replay resolves taken
      inst = itype(6'h04, 6, 0, 16'd1); inst_pc = 8'h40; #1;
      chk("bh_pcw", pc_write, 1);
      chk("bh_pcin", pc_in, 8'h44);
      step();
      chk("bh_bubble", ex_valid, 0);
      inst = BUB; #1;
      chk("bh_rp_pcin", pc_in, 8'h48);
      step(); step();

      // Branch hazard on a load in MEM
      mem_mem_read = 1; mem_rd = 1;
      inst = itype(6'h04, 0, 1, 16'd2); inst_pc = 8'h50; #1;
      chk("mh_pcw", pc_write, 1);
      chk("mh_pcin", pc_in, 8'h54);
      step(); mem_mem_read = 0; inst = BUB;
      step();

      // Branch target wrap-around
      inst = itype(6'h04, 0, 0, 16'd1); inst_pc = 8'hFC; #1;
      chk("wrap_pcw", pc_write, 1);
      chk("wrap_pcin", pc_in, 8'h04);
      step(); inst = BUB; step();

      // r0 is hard-wired zero
      wb_we = 1; wb_addr = 0; wb_data = 32'h99; step();
      inst = rtype(0, 0, 1, 6'h20); step(); wb_we = 0;
      chk("r0_valid", ex_valid, 1);
      chk("r0_rs", ex_rs_val, 0);
      chk("r0_rt", ex_rt_val, 0);

      // Illegal opcode / funct become bubbles
      inst = BUB; #1;
      chk("ill_pcw", pc_write, 0);
      step();
      chk("ill_valid", ex_valid, 0);
      chk("ill_regw", ex_reg_write, 0);
      inst = rtype(1, 1, 6, 6'h21); step();
      chk("badfn_valid", ex_valid, 0);

      // Reset while in REPLAY
      inst = itype(6'h23, 0, 2, 0); inst_pc = 8'h60; step();
      inst = rtype(2, 0, 5, 6'h20); inst_pc = 8'h64; step();
      #2; reset = 1'b0; #1;
      chk("rr_valid", ex_valid, 0);
      chk("rr_pcw", pc_write, 0);
      step();
      reset = 1'b1;
      inst = rtype(1, 0, 7, 6'h20); inst_pc = 8'h70; #1;
      chk("rr_run_pcw", pc_write, 0);
      step();
      chk("rr_run_valid", ex_valid, 1);
      chk("rr_run_rd", ex_rd, 7);
      chk("rr_r1_zero", ex_rs_val, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
